sisa_mem_arbiter: RTL
=====================

Name: sisa_mem_arbiter

Overview:
- Shares one Avalon-MM memory master port between the SISA pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage).
- Grants one transaction at a time, with at most one outstanding read.
- Data port has priority because it belongs to the older instruction; a streak limit prevents fetch starvation.
- Sits between the core's two bus ports and the system interconnect; one instance per core.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced; legal range is 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- f_read  in  1  fetch read request, held until accepted.
- f_address  in  ADDR_W  fetch address.
- f_waitrequest  out  1  high = fetch request not accepted this cycle.
- f_readdata  out  DATA_W  fetch read data.
- f_readdatavalid  out  1  one-cycle pulse qualifying f_readdata.
- f_flush  in  1  discard any accepted, not-yet-returned fetch read.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_address  in  ADDR_W  data address.
- d_writedata  in  DATA_W  write data.
- d_byteenable  in  DATA_W/8  write/read byte lanes.
- d_waitrequest  out  1  high = data request not accepted.
- d_readdata  out  DATA_W  data read data.
- d_readdatavalid  out  1  one-cycle pulse qualifying d_readdata.
- m_read  out  1  memory read.
- m_write  out  1  memory write.
- m_address  out  ADDR_W  memory address.
- m_writedata  out  DATA_W  memory write data.
- m_byteenable  out  DATA_W/8  memory byte enables; all ones for fetch.
- m_waitrequest  in  1  memory stall.
- m_readdata  in  DATA_W  memory read data.
- m_readdatavalid  in  1  memory read data valid.
- grant  out  2  current owner: 01 = fetch, 10 = data, 00 = none.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; grant = 00; streak counter = 0; drop flag = 0.
  - m_read = m_write = 0.
  - f_waitrequest = d_waitrequest = 1.
  - Both readdatavalid outputs = 0.
  - Reset mid-transaction abandons it; any later m_readdatavalid is ignored while IDLE.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any request is present, register the winner into grant and go to ISSUE next cycle.
  - Otherwise stay in IDLE.
- Arbitration, evaluated in IDLE:
  - Data wins if it is requesting, unless f_read=1 and streak == MAX_DATA_STREAK; then fetch wins.
  - Streak increments on a data grant made while f_read=1.
  - Streak clears on a fetch grant, or on a data grant made while f_read=0.
  - Streak saturates at MAX_DATA_STREAK.
- ISSUE:
  - m_* are driven combinationally from the granted port's live inputs; requesters hold them stable while their waitrequest is high.
  - When m_waitrequest=0, the granted port's waitrequest is low for exactly that cycle (acceptance).
  - Accepted write: go to IDLE.
  - Accepted read: go to WAIT_RD.
  - The non-granted port's waitrequest stays high throughout.
- d_read and d_write asserted together is illegal; the write is performed and the read is ignored.
- WAIT_RD:
  - m_read = m_write = 0.
  - On m_readdatavalid, the granted port's readdatavalid pulses that same cycle (combinational pass).
  - Both readdata outputs carry m_readdata.
  - State then returns to IDLE.
- Minimum read turnaround, with no memory waits and memory latency L:
  - Request seen in IDLE at cycle 0.
  - Accepted at cycle 1.
  - Valid at cycle 1+L.
  - Next grant decision at cycle 2+L.
- Fetch flush:
  - f_flush=1 while WAIT_RD with fetch grant sets the drop flag.
  - The returning data is consumed with f_readdatavalid held at 0; the flag clears on return.
  - Flush in the same cycle as m_readdatavalid also suppresses the pulse.
  - Flush in any other state has no effect; a fetch in ISSUE must still complete its handshake.
- Back-to-back operation: no bubble is required beyond the mandatory IDLE cycle between transactions.

Test Plan:
- Reset held 2 cycles, then idle with no requests -> grant = 00, m_read = m_write = 0, both waitrequests = 1, no valid pulses.
- f_read, f_address = 0x100, memory with no waits and L = 2 returning 0xDEADBEEF -> f_waitrequest low at cycle 1 only; f_readdatavalid = 1 with f_readdata = 0xDEADBEEF at cycle 3; grant = 01 during cycles 1-3.
- d_write to 0x2000 with data 0x12345678, byteenable 0xF, and f_read arriving in the same cycle -> the write reaches memory first (m_write = 1, grant = 10); the fetch is granted in the IDLE decision after the write completes.
- d_read requested continuously and f_read held -> grants are data, data, data, data, then fetch (MAX_DATA_STREAK = 4); the streak restarts afterwards.
- Fetch read accepted, f_flush pulsed 1 cycle before m_readdatavalid -> no f_readdatavalid; a following d_read is granted normally.
- reset asserted while in WAIT_RD, with m_readdatavalid arriving 1 cycle after reset deasserts -> no readdatavalid on either port; grant = 00; state is IDLE.

Source files
------------

// File: rtl/sisa_mem_arbiter.sv
// Arbitrates one Avalon-MM master port between the SISA fetch (IF) and data (MEM) requesters.
// Data has priority; a saturating streak counter forces a fetch grant after MAX_DATA_STREAK data wins.
module sisa_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_read,
  input  logic [ADDR_W-1:0]   f_address,
  output logic                f_waitrequest,
  output logic [DATA_W-1:0]   f_readdata,
  output logic                f_readdatavalid,
  input  logic                f_flush,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  output logic                m_read,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [1:0]          grant
);

  localparam logic [1:0] GNT_NONE   = 2'b00;
  localparam logic [1:0] GNT_F      = 2'b01;
  localparam logic [1:0] GNT_D      = 2'b10;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t     state;
  logic [3:0] streak;
  logic       drop;

  logic data_req;
  logic any_req;
  logic fetch_wins;
  logic issue_f;
  logic issue_d;
  logic in_wait;

  function automatic logic [3:0] streak_inc(input logic [3:0] s);
    if (s >= STREAK_MAX) return STREAK_MAX;
    return s + 4'd1;
  endfunction

  assign data_req   = d_read | d_write;
  assign any_req    = f_read | data_req;
  assign fetch_wins = f_read & (~data_req | (streak == STREAK_MAX));
  assign issue_f    = (state == ISSUE) & (grant == GNT_F);
  assign issue_d    = (state == ISSUE) & (grant == GNT_D);
  assign in_wait    = (state == WAIT_RD);

  // Memory side follows the owner's live request; a simultaneous data read+write performs only the write.
  always_comb begin
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = f_address;
    m_writedata  = d_writedata;
    m_byteenable = '1;
    if (grant == GNT_D) begin
      m_address    = d_address;
      m_byteenable = d_byteenable;
    end
    if (issue_f) begin
      m_read = f_read;
    end else if (issue_d) begin
      m_write = d_write;
      m_read  = d_read & ~d_write;
    end
  end

  assign f_waitrequest   = ~(issue_f & ~m_waitrequest);
  assign d_waitrequest   = ~(issue_d & ~m_waitrequest);
  assign f_readdata      = m_readdata;
  assign d_readdata      = m_readdata;
  assign f_readdatavalid = in_wait & m_readdatavalid & (grant == GNT_F) & ~drop & ~f_flush;
  assign d_readdatavalid = in_wait & m_readdatavalid & (grant == GNT_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= GNT_NONE;
      streak <= 4'd0;
      drop   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= ISSUE;
            if (fetch_wins) begin
              grant  <= GNT_F;
              streak <= 4'd0;
            end else begin
              grant  <= GNT_D;
              streak <= f_read ? streak_inc(streak) : 4'd0;
            end
          end
        end
        ISSUE: begin
          if (!m_waitrequest) begin
            if (m_read) begin
              state <= WAIT_RD;
            end else begin
              state <= IDLE;
              grant <= GNT_NONE;
            end
          end
        end
        WAIT_RD: begin
          if (m_readdatavalid) begin
            state <= IDLE;
            grant <= GNT_NONE;
            drop  <= 1'b0;
          end else if ((grant == GNT_F) && f_flush) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

endmodule
